// File: rtl/plb_pkg.sv
// Shared PLB definitions: initiator FSM state encoding and the
// default read-data pattern returned when a transaction times out.
package plb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STROBE = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } plb_state_t;

    localparam logic [31:0] PLB_TIMEOUT_DATA = 32'hDEAD_0BAD;

endpackage

// File: rtl/plb_initiator.sv
// Single-outstanding PLB bus initiator: accepts a command, issues a
// one-cycle strobe, waits for plbReady (or times out), returns a response.
// Ports:
//   clk, rst                          clock, sync active-high reset
//   cmdValid/cmdReady, cmdWrite,
//   cmdAddr, cmdBE, cmdData           command handshake and payload
//   rspValid/rspReady, rspData,
//   rspTimeout                        response handshake and payload
//   plbEn/plbRd/plbWr, plbAddr,
//   plbBE, plbWrData                  bus request strobes and fields
//   plbReady, plbRdData               responder completion and data
//   busy, strayReady                  status: not idle / sticky stray ready
module plb_initiator
    import plb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] TIMEOUT_DATA   = PLB_TIMEOUT_DATA
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmdValid,
    output logic        cmdReady,
    input  logic        cmdWrite,
    input  logic [31:0] cmdAddr,
    input  logic [3:0]  cmdBE,
    input  logic [31:0] cmdData,
    output logic        rspValid,
    input  logic        rspReady,
    output logic [31:0] rspData,
    output logic        rspTimeout,
    output logic        plbEn,
    output logic        plbRd,
    output logic        plbWr,
    output logic [31:0] plbAddr,
    output logic [3:0]  plbBE,
    output logic [31:0] plbWrData,
    input  logic        plbReady,
    input  logic [31:0] plbRdData,
    output logic        busy,
    output logic        strayReady
);

    localparam logic [15:0] LP_LAST = 16'(TIMEOUT_CYCLES - 1);

    plb_state_t  r_state;
    plb_state_t  w_state_nxt;
    logic        r_write;
    logic [31:0] r_addr;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;
    logic [31:0] r_rsp_data;
    logic        r_rsp_to;
    logic [15:0] r_cnt;
    logic        r_stray;

    logic        w_accept;
    logic [31:0] w_rsp_data_nxt;
    logic        w_rsp_to_nxt;
    logic [15:0] w_cnt_nxt;
    logic        w_stray_hit;

    always_comb begin
        w_state_nxt    = r_state;
        w_accept       = 1'b0;
        w_rsp_data_nxt = r_rsp_data;
        w_rsp_to_nxt   = r_rsp_to;
        w_cnt_nxt      = r_cnt;
        unique case (r_state)
            IDLE: begin
                if (cmdValid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = STROBE;
                end
            end
            STROBE: begin
                // plbReady is not a completion here; count starts fresh
                w_cnt_nxt   = 16'd0;
                w_state_nxt = WAIT;
            end
            WAIT: begin
                // ready wins over a timeout landing on the same cycle
                if (plbReady) begin
                    w_rsp_data_nxt = r_write ? 32'h0 : plbRdData;
                    w_rsp_to_nxt   = 1'b0;
                    w_state_nxt    = RESP;
                end else if (r_cnt == LP_LAST) begin
                    w_rsp_data_nxt = r_write ? 32'h0 : TIMEOUT_DATA;
                    w_rsp_to_nxt   = 1'b1;
                    w_state_nxt    = RESP;
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            RESP: begin
                if (rspReady) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign w_stray_hit = plbReady && (r_state != WAIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_write    <= 1'b0;
            r_addr     <= 32'h0;
            r_be       <= 4'h0;
            r_wdata    <= 32'h0;
            r_rsp_data <= 32'h0;
            r_rsp_to   <= 1'b0;
            r_cnt      <= 16'd0;
            r_stray    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_rsp_data <= w_rsp_data_nxt;
            r_rsp_to   <= w_rsp_to_nxt;
            r_cnt      <= w_cnt_nxt;
            if (w_stray_hit) begin
                r_stray <= 1'b1;
            end
            if (w_accept) begin
                r_write <= cmdWrite;
                r_addr  <= cmdAddr;
                r_be    <= cmdBE;
                r_wdata <= cmdData;
            end
        end
    end

    assign cmdReady   = (r_state == IDLE);
    assign rspValid   = (r_state == RESP);
    assign busy       = (r_state != IDLE);
    assign plbEn      = (r_state == STROBE);
    assign plbWr      = (r_state == STROBE) && r_write;
    assign plbRd      = (r_state == STROBE) && !r_write;
    assign plbAddr    = r_addr;
    assign plbBE      = r_be;
    assign plbWrData  = r_wdata;
    assign rspData    = r_rsp_data;
    assign rspTimeout = r_rsp_to;
    assign strayReady = r_stray;

endmodule
